emu_dec_gen: RTL
================

Name: emu_dec_gen

Overview:
- Decimation strobe generator that sits directly downstream of the emulator control-signal source.
- Consumes the run enable and the decimation threshold `emu_dec_thr`.
- Produces a one-cycle sample strobe `emu_dec_cmp` that gates probe/ILA capture, so emulator state is recorded every (thr+1) enabled emu_clk cycles.
- Also reports the live count, the active threshold and a saturating count of issued samples for host readback.

Parameters:
- dec_bits, 1, width of emu_dec_thr, emu_dec_cnt and emu_dec_thr_act.
- smp_bits, 32, width of the sample counter emu_smp_cnt.

Ports:
- emu_clk  input  1  emulator clock; all state changes on its rising edge.
- emu_rst_n  input  1  asynchronous, active-low reset.
- emu_en  input  1  run enable (inverted, synchronised emu_rst from the control source); counting only while high.
- emu_dec_thr  input  dec_bits  requested decimation threshold; may change at any time.
- emu_dec_cmp  output  1  registered sample strobe, one cycle wide.
- emu_dec_cnt  output  dec_bits  current decimation count.
- emu_dec_thr_act  output  dec_bits  threshold currently in effect.
- emu_smp_cnt  output  smp_bits  number of strobes issued since reset, saturating.
- emu_smp_sat  output  1  high once emu_smp_cnt has reached all-ones.

Behaviour:
- Clock and reset: one clock, emu_clk. emu_rst_n is asynchronous and active-low.
- Reset (emu_rst_n=0, asynchronous): state=IDLE, emu_dec_cmp=0, emu_dec_cnt=0, emu_dec_thr_act=0, emu_smp_cnt=0, emu_smp_sat=0. Deassertion takes effect at the next emu_clk edge.
- FSM has two states, IDLE and RUN. Only reset returns the FSM to IDLE.
- IDLE, emu_en=0: hold all registers; emu_dec_cmp=0.
- IDLE, emu_en=1: emu_dec_thr_act<=emu_dec_thr; emu_dec_cnt<=0; emu_dec_cmp<=0; go to RUN.
- RUN, emu_en=0 (pause): emu_dec_cnt, emu_dec_thr_act, emu_smp_cnt all hold; emu_dec_cmp<=0. Counting resumes from the held value when emu_en returns.
- RUN, emu_en=1, emu_dec_cnt==emu_dec_thr_act (wrap):
  - emu_dec_cmp<=1; emu_dec_cnt<=0; emu_dec_thr_act<=emu_dec_thr.
  - emu_smp_cnt<=emu_smp_cnt+1 unless all-ones, in which case it holds.
- RUN, emu_en=1, otherwise: emu_dec_cnt<=emu_dec_cnt+1; emu_dec_cmp<=0.
- Strobe period: thr+1 enabled cycles.
  - thr=0: strobe on every enabled RUN cycle, held high continuously.
  - Maximum thr=2^dec_bits-1 needs no overflow handling, since the count wraps on compare.
- First strobe: with IDLE->RUN on edge E, the first emu_dec_cmp=1 is visible after edge E+thr+1.
- Threshold changes: take effect only at wrap, never mid-period. A change in IDLE is captured at the IDLE->RUN transition.
- Pause on the wrap cycle: if emu_en falls in the cycle where the compare would hit, no strobe is issued and the count holds. The strobe is issued on the first enabled cycle after resume.
- Saturation:
  - emu_smp_sat is registered and goes high on the same edge emu_smp_cnt becomes all-ones.
  - Strobes keep firing after saturation; only the counter stops.
- Reset mid-period: immediately clears everything, including a strobe in flight. There is no glitch-free requirement on outputs during reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset/idle: emu_rst_n=0 then 1 with emu_en=0 for 10 cycles -> all outputs 0, state IDLE.
- thr=3, dec_bits=2: raise emu_en at edge 0 -> emu_dec_cmp=1 after edges 4, 8, 12; emu_dec_cnt sequence 0,1,2,3,0; emu_smp_cnt=3 after edge 12.
- thr=0: emu_en high 5 cycles after IDLE->RUN -> emu_dec_cmp high on edges 1..5; emu_smp_cnt=5.
- Threshold change mid-period: thr=3 running, change to 1 at cnt=1 -> current period completes at cnt=3 with a strobe, thr_act becomes 1, next strobes every 2 cycles.
- Pause at wrap, thr=2: drop emu_en in the cycle cnt==2 for 3 cycles -> no strobe, cnt holds at 2; strobe on the first re-enabled edge.
- Saturation, smp_bits=3, thr=0: run 10 cycles -> emu_smp_cnt stops at 7 with emu_smp_sat=1 from that edge; strobe continues. Assert emu_rst_n=0 mid-run -> immediate clear of all outputs.

Source files
------------

// File: rtl/emu_dec_gen.sv
// emu_dec_gen: decimation strobe generator emitting one capture strobe every thr+1 enabled emu_clk cycles
module emu_dec_gen #(
   parameter int dec_bits = 1,
   parameter int smp_bits = 32
) (
   input  logic                emu_clk,
   input  logic                emu_rst_n,
   input  logic                emu_en,
   input  logic [dec_bits-1:0] emu_dec_thr,
   output logic                emu_dec_cmp,
   output logic [dec_bits-1:0] emu_dec_cnt,
   output logic [dec_bits-1:0] emu_dec_thr_act,
   output logic [smp_bits-1:0] emu_smp_cnt,
   output logic                emu_smp_sat
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t              state_q, state_d;
   logic                cmp_q, cmp_d, sat_q, sat_d;
   logic [dec_bits-1:0] cnt_q, cnt_d, thr_q, thr_d;
   logic [smp_bits-1:0] smp_q, smp_d;
   logic                wrap;
   assign wrap = state_q == RUN && emu_en && cnt_q == thr_q;
   always_comb begin
      state_d = emu_en ? RUN : state_q;
      cmp_d   = wrap;
      cnt_d   = !emu_en ? cnt_q : (state_q == IDLE || wrap) ? '0 : cnt_q + 1'b1;
      thr_d   = (emu_en && (state_q == IDLE || wrap)) ? emu_dec_thr : thr_q;
      smp_d   = (wrap && !(&smp_q)) ? smp_q + 1'b1 : smp_q;
      sat_d   = &smp_d;
   end
   always_ff @(posedge emu_clk or negedge emu_rst_n) begin
      if (!emu_rst_n) begin
         state_q <= IDLE;
         cmp_q   <= 1'b0;
         cnt_q   <= '0;
         thr_q   <= '0;
         smp_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cmp_q   <= cmp_d;
         cnt_q   <= cnt_d;
         thr_q   <= thr_d;
         smp_q   <= smp_d;
         sat_q   <= sat_d;
      end
   end
   assign emu_dec_cmp     = cmp_q;
   assign emu_dec_cnt     = cnt_q;
   assign emu_dec_thr_act = thr_q;
   assign emu_smp_cnt     = smp_q;
   assign emu_smp_sat     = sat_q;
endmodule
